// File: rtl/m68k_bus_pkg.sv
// Shared types and constants for the 68000 bus-mastership arbiter.
package m68k_bus_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQUEST  = 3'd1,
        WAIT_BUS = 3'd2,
        OWN      = 3'd3,
        RELEASE  = 3'd4,
        HOLDOFF  = 3'd5
    } state_t;

    localparam int SYNC_STAGES = 2;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/m68k_sync.sv
// Multi-bit flop-chain synchronizer for asynchronous 68k bus-monitor pins.
module m68k_sync
    import m68k_bus_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];

    // Pins idle high, so reset the chain to the inactive level.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= RESET_VAL;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/m68k_bus_arbiter.sv
// BR/BG/BGACK bus-mastership controller letting one internal master take the 68000 bus.
// Handshake: REQ is a level held for the whole tenure; GNT high means the master may drive the bus.
module m68k_bus_arbiter
    import m68k_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MAX_TENURE     = 64,
    parameter int HOLDOFF_CYCLES = 2
) (
    input  logic   CLK,
    input  logic   RESET,
    input  logic   BG,
    input  logic   BGACK,
    input  logic   AS,
    input  logic   DTACK,
    input  logic   REQ,
    input  logic   DONE,
    output logic   BR_OE,
    output logic   BGACK_OE,
    output logic   GNT,
    output logic   REL_REQ,
    output logic   TIMEOUT,
    output state_t state_dbg_o
);

    // One counter serves timeout, tenure and holdoff; it clears on every state change.
    localparam int CNT_LIMIT = max3(TIMEOUT_CYCLES, MAX_TENURE, HOLDOFF_CYCLES);
    localparam int CNT_W     = $clog2(CNT_LIMIT + 1);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] HO_LIM  = CNT_W'(HOLDOFF_CYCLES);
    localparam logic [CNT_W:0]   TEN_LIM = (CNT_W+1)'(MAX_TENURE);

    logic [3:0] pins_s;
    logic       bg_s, bgack_s, as_s, dtack_s;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [CNT_W:0]   tenure_idx;
    logic             br_oe_q, br_oe_d;
    logic             gnt_q, gnt_d;
    logic             rel_q, rel_d;
    logic             timeout_q, timeout_d;

    m68k_sync #(
        .WIDTH     (4),
        .RESET_VAL (4'b1111)
    ) u_sync (
        .clk_i (CLK),
        .rst_i (RESET),
        .d_i   ({BG, BGACK, AS, DTACK}),
        .q_o   (pins_s)
    );

    assign {bg_s, bgack_s, as_s, dtack_s} = pins_s;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            br_oe_q   <= 1'b0;
            gnt_q     <= 1'b0;
            rel_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            br_oe_q   <= br_oe_d;
            gnt_q     <= gnt_d;
            rel_q     <= rel_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

        unique case (state_q)
            IDLE: begin
                if (REQ) state_d = REQUEST;
            end
            REQUEST: begin
                if (!bg_s)                 state_d = WAIT_BUS;
                else if (cnt_inc >= TO_LIM) state_d = HOLDOFF;
                else if (!REQ)             state_d = IDLE;
            end
            WAIT_BUS: begin
                if (!REQ)                              state_d = HOLDOFF;
                else if (as_s && dtack_s && bgack_s)   state_d = OWN;
            end
            OWN: begin
                if (DONE || !REQ) state_d = RELEASE;
            end
            RELEASE: begin
                state_d = HOLDOFF;
            end
            HOLDOFF: begin
                if (cnt_inc >= HO_LIM) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cnt_d = (state_d != state_q) ? '0 : cnt_inc;

        // BR follows the previous state, so it overlaps BGACK by exactly one cycle.
        br_oe_d = (state_q == REQUEST) || (state_q == WAIT_BUS);

        // GNT/BGACK rise on OWN entry and stay up through the RELEASE cycle.
        gnt_d = (state_q == OWN) || (state_d == OWN);

        // Index of the upcoming OWN cycle (1-based) decides when REL_REQ shows.
        tenure_idx = (state_q == OWN) ? ({1'b0, cnt_q} + (CNT_W+1)'(2)) : (CNT_W+1)'(1);
        rel_d      = (state_d == OWN) && (tenure_idx >= TEN_LIM);

        timeout_d = (state_q == REQUEST) && (state_d == HOLDOFF);
    end

    assign BR_OE       = br_oe_q;
    assign BGACK_OE    = gnt_q;
    assign GNT         = gnt_q;
    assign REL_REQ     = rel_q;
    assign TIMEOUT     = timeout_q;
    assign state_dbg_o = state_q;

endmodule

// File: doc/m68k_bus_arbiter.md
# m68k_bus_arbiter

Bus-mastership controller for the 68000 dev-board CPLD. It lets one on-CPLD alternate master (DMA or test engine) acquire the 68000 bus via the three-wire BR/BG/BGACK protocol. It waits for the current CPU cycle to finish, holds BGACK for the tenure, and hands the bus back cleanly. It sits between the bus-monitor pins (BG, BGACK, AS, DTACK) and the internal master's REQ/GNT handshake.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: CLK cycles to wait for BG before abandoning a request.
- MAX_TENURE, 64: CLK cycles of ownership before REL_REQ is raised.
- HOLDOFF_CYCLES, 2: minimum idle gap between releasing the bus and re-asserting BR.

Ports. The 68k bus signals are active-low pin levels. The *_OE outputs are 1 to pull the open-drain pin low.
- CLK  in  1  board clock; only clock.
- RESET  in  1  synchronous, active-high reset.
- BG  in  1  CPU bus grant, pin level, asynchronous.
- BGACK  in  1  bus grant acknowledge, pin level, asynchronous.
- AS  in  1  address strobe, pin level, asynchronous.
- DTACK  in  1  data acknowledge, pin level, asynchronous.
- REQ  in  1  internal master requests the bus (level).
- DONE  in  1  internal master has finished its last cycle (pulse or level).
- BR_OE  out  1  drive BR low.
- BGACK_OE  out  1  drive BGACK low.
- GNT  out  1  internal master owns the bus.
- REL_REQ  out  1  tenure expired; master must finish and raise DONE.
- TIMEOUT  out  1  one-cycle pulse when a request is abandoned.

## Operation
- BG, BGACK, AS and DTACK each pass through a 2-flop synchronizer. All decisions use the synchronized values (bg_s, bgack_s, as_s, dtack_s).
- **IDLE**
  - REQ=1 → REQUEST.
- **REQUEST**
  - BR_OE=1; counter increments each cycle.
  - bg_s=0 → WAIT_BUS.
  - REQ=0 → IDLE, BR_OE=0 on the next cycle.
  - Counter reaches TIMEOUT_CYCLES → HOLDOFF, TIMEOUT pulse.
- **WAIT_BUS**
  - BR_OE=1.
  - Waits for as_s=1, dtack_s=1 and bgack_s=1 in the same cycle, then → OWN.
  - REQ=0 → HOLDOFF without ever asserting BGACK.
- **OWN**
  - BGACK_OE=1 and GNT=1 from the entry cycle.
  - BR_OE=0 from the second OWN cycle onward.
  - Tenure counter starts at entry. At MAX_TENURE, REL_REQ=1 (sticky until exit).
  - DONE=1 or REQ=0 → RELEASE.
- **RELEASE**
  - GNT=0, BGACK_OE=0, BR_OE=0 for one cycle → HOLDOFF.
- **HOLDOFF**
  - All outputs 0 for HOLDOFF_CYCLES cycles → IDLE. REQ is ignored during this state.
- Simultaneous events:
  - In REQUEST, bg_s=0 takes priority over timeout, and timeout takes priority over REQ=0.
  - In OWN, DONE and REQ=0 in the same cycle are treated as a single release.
- Counters saturate and never wrap. Each counter's width is clog2(parameter+1).

## Timing
- Reset values: BR_OE=0, BGACK_OE=0, GNT=0, REL_REQ=0, TIMEOUT=0, state=IDLE, counters=0.
- RESET asserted mid-tenure releases the bus on the next edge.
- All outputs are registered.
- REQ rising in IDLE → BR_OE=1 at edge +2.
- Pin BG falling → state WAIT_BUS 3 edges later (2 synchronizer edges + 1 state edge).
- Bus-free condition → BGACK_OE=1 and GNT=1 at the next edge.
- BR_OE drops exactly one cycle after BGACK_OE rises. BGACK is never asserted while as_s=0.
- DONE seen → GNT and BGACK_OE low at edge +2 (passes through RELEASE).
- The gap between BGACK_OE falling and the next BR_OE rising is at least HOLDOFF_CYCLES+1 cycles.

## Structure
- Shared package m68k_bus_pkg holds:
  - the state enum (IDLE, REQUEST, WAIT_BUS, OWN, RELEASE, HOLDOFF);
  - the synchronizer depth constant (2).
- Sub-module m68k_sync: a parameterized-width 2-flop synchronizer, instantiated once for the 4-bit vector {BG, BGACK, AS, DTACK}.
- The state machine and the three counters (timeout, tenure, holdoff) live in m68k_bus_arbiter. They may share one counter register, cleared on every state change.

## Test plan
- Normal grant: REQ=1, BG pulled low 5 cycles later, AS/DTACK/BGACK high → BGACK_OE=1 and GNT=1 at the expected edge; BR_OE=0 one cycle later; DONE → all outputs 0 two cycles later.
- Bus busy: BG low while AS low for 10 cycles → no BGACK_OE until 1 edge after as_s returns high.
- Timeout: REQ=1, BG held high, TIMEOUT_CYCLES=8 → TIMEOUT pulse after 8 REQUEST cycles; BR_OE=0; no new BR for 2 cycles.
- Tenure: MAX_TENURE=16, DONE withheld → REL_REQ=1 at the 16th OWN cycle; DONE 3 cycles later → release.
- Withdrawal: REQ dropped in WAIT_BUS → BR_OE=0 and BGACK_OE never asserted.
- Reset in OWN: RESET=1 for one edge → every output 0 on that edge, state IDLE.
